// File: rtl/instmem_port_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its requesters
// (fetch unit, access-mem stage) and the single-port instruction SRAM.
interface instmem_port_arbiter_if #(
   parameter int CPU_WIDTH = 32
);
   logic                 fetch_req_i;
   logic [CPU_WIDTH-1:0] fetch_addr_i;
   logic                 ls_req_i;
   logic                 ls_we_i;
   logic [CPU_WIDTH-1:0] ls_addr_i;
   logic [CPU_WIDTH-1:0] ls_wdata_i;
   logic [3:0]           ls_wmask_i;
   logic [CPU_WIDTH-1:0] mem_rdata_i;
   logic [CPU_WIDTH-1:0] mem_addr_o;
   logic                 mem_we_o;
   logic [3:0]           mem_wmask_o;
   logic [CPU_WIDTH-1:0] mem_wdata_o;
   logic                 fetch_rvalid_o;
   logic                 ls_gnt_o;
   logic                 ls_rvalid_o;
   logic [CPU_WIDTH-1:0] ls_rdata_o;
   logic [1:0]           pr_acess_instmem_o;

   // arbiter side
   modport slave (
      input  fetch_req_i, fetch_addr_i, ls_req_i, ls_we_i, ls_addr_i,
             ls_wdata_i, ls_wmask_i, mem_rdata_i,
      output mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o, fetch_rvalid_o,
             ls_gnt_o, ls_rvalid_o, ls_rdata_o, pr_acess_instmem_o
   );

   // requester / SRAM side
   modport master (
      output fetch_req_i, fetch_addr_i, ls_req_i, ls_we_i, ls_addr_i,
             ls_wdata_i, ls_wmask_i, mem_rdata_i,
      input  mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o, fetch_rvalid_o,
             ls_gnt_o, ls_rvalid_o, ls_rdata_o, pr_acess_instmem_o
   );
endinterface

// File: rtl/instmem_port_arbiter.sv
// Shares the single-port instruction SRAM between fetch and load/store.
// A load/store takes two cycles (issue, then response + fetch refetch);
// bursts are capped at LS_BURST_MAX so fetch always gets a slot.
module instmem_port_arbiter #(
   parameter int CPU_WIDTH    = 32,
   parameter int LS_BURST_MAX = 4,
   parameter int CNT_W        = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   instmem_port_arbiter_if.slave  bus
);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(LS_BURST_MAX);

   typedef enum logic [1:0] {IDLE, LS_ISSUE, LS_RESP} state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     burst_cnt, burst_cnt_n;
   logic                 ls_we_q;
   logic                 forced_q;      // this IDLE cycle belongs to fetch
   logic                 fetch_rvalid_q;
   logic                 fetch_sel;     // fetch_addr_i is on the SRAM address
   logic [CPU_WIDTH-1:0] addr_mux;
   logic                 we, gnt, rvalid;
   logic [3:0]           wmask;
   logic [1:0]           pr;

   // state, burst counter and registered response flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         burst_cnt      <= '0;
         ls_we_q        <= 1'b0;
         forced_q       <= 1'b0;
         fetch_rvalid_q <= 1'b0;
      end else begin
         state          <= state_n;
         burst_cnt      <= burst_cnt_n;
         if (state == LS_ISSUE) ls_we_q <= bus.ls_we_i;
         // a full burst ending in LS_RESP forces the next IDLE to fetch
         forced_q       <= (state == LS_RESP) && (burst_cnt == BURST_MAX);
         fetch_rvalid_q <= fetch_sel && bus.fetch_req_i;
      end
   end

   // next state, SRAM port mux and pipeline hold code
   always_comb begin
      state_n     = state;
      burst_cnt_n = burst_cnt;
      addr_mux    = bus.fetch_addr_i;
      we          = 1'b0;
      wmask       = 4'b0000;
      gnt         = 1'b0;
      rvalid      = 1'b0;
      pr          = 2'b00;
      fetch_sel   = 1'b0;
      case (state)
         IDLE: begin
            fetch_sel   = 1'b1;
            burst_cnt_n = '0;
            if (bus.ls_req_i && !forced_q) state_n = LS_ISSUE;
         end
         LS_ISSUE: begin
            addr_mux    = bus.ls_addr_i;
            we          = bus.ls_we_i;
            wmask       = bus.ls_we_i ? bus.ls_wmask_i : 4'b0000;
            gnt         = 1'b1;
            pr          = 2'b10;
            burst_cnt_n = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
            state_n     = LS_RESP;
         end
         LS_RESP: begin
            fetch_sel = 1'b1;
            pr        = 2'b01;
            rvalid    = ~ls_we_q;
            if (bus.ls_req_i && (burst_cnt < BURST_MAX)) state_n = LS_ISSUE;
            else                                         state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // state register still holds the old state during reset; mask it
      if (rst) begin
         addr_mux = bus.fetch_addr_i;
         we       = 1'b0;
         wmask    = 4'b0000;
         gnt      = 1'b0;
         rvalid   = 1'b0;
         pr       = 2'b00;
      end
   end

   assign bus.mem_addr_o         = addr_mux;
   assign bus.mem_we_o           = we;
   assign bus.mem_wmask_o        = wmask;
   assign bus.mem_wdata_o        = bus.ls_wdata_i;
   assign bus.fetch_rvalid_o     = fetch_rvalid_q;
   assign bus.ls_gnt_o           = gnt;
   assign bus.ls_rvalid_o        = rvalid;
   assign bus.ls_rdata_o         = bus.mem_rdata_i;
   assign bus.pr_acess_instmem_o = pr;
endmodule

// File: tb/tb_instmem_port_arbiter.sv
// Bench for instmem_port_arbiter: SRAM model plus scoreboard queues for
// fetch and load returns, with per-scenario directed tasks.
module tb_instmem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic [31:0] sram [0:1023];
   logic [31:0] fq [$];
   logic [31:0] lq [$];

   instmem_port_arbiter_if #(.CPU_WIDTH(32)) bus ();

   instmem_port_arbiter #(.CPU_WIDTH(32), .LS_BURST_MAX(4), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      case (a)
         32'h200: return 32'hDEADBEEF;
         32'h300: return 32'hAAAAAAAA;
         32'h3F0: return 32'h55555555;
         default: return 32'h1000_0000 + a;
      endcase
   endfunction

   // synchronous SRAM: byte-masked write, read data one cycle after address
   always @(posedge clk) begin
      if (bus.mem_we_o)
         for (int b = 0; b < 4; b++)
            if (bus.mem_wmask_o[b])
               sram[bus.mem_addr_o[11:2]][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
      bus.mem_rdata_i <= sram[bus.mem_addr_o[11:2]];
   end

   // scoreboard: pop expected data whenever the DUT flags a return
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst) begin
         if (bus.fetch_rvalid_o) begin
            checks++;
            if (fq.size() == 0) begin
               errors++;
               $display("FAIL fetch_spurious: got rvalid data %h, want no return", bus.mem_rdata_i);
            end else begin
               e = fq.pop_front();
               if (bus.mem_rdata_i !== e) begin
                  errors++;
                  $display("FAIL fetch_data: got %h want %h", bus.mem_rdata_i, e);
               end
            end
         end
         if (bus.ls_rvalid_o) begin
            checks++;
            if (lq.size() == 0) begin
               errors++;
               $display("FAIL ls_spurious: got rvalid data %h, want no return", bus.ls_rdata_o);
            end else begin
               e = lq.pop_front();
               if (bus.ls_rdata_o !== e) begin
                  errors++;
                  $display("FAIL ls_data: got %h want %h", bus.ls_rdata_o, e);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.fetch_req_i = 1'b0;
      bus.ls_req_i    = 1'b0;
      bus.ls_we_i     = 1'b0;
      bus.ls_wmask_i  = 4'b0000;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.fetch_addr_i = 32'h40;
      rst = 1'b1;
      tick(); tick();
      #2;
      checks++; if (bus.pr_acess_instmem_o !== 2'b00) begin errors++; $display("FAIL rst_pr: got %b want 00", bus.pr_acess_instmem_o); end
      checks++; if (bus.mem_addr_o !== 32'h40) begin errors++; $display("FAIL rst_addr: got %h want 00000040", bus.mem_addr_o); end
      checks++; if (bus.fetch_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_frv: got %b want 0", bus.fetch_rvalid_o); end
      // store request, then reset lands in its LS_ISSUE cycle
      rst = 1'b0;
      bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b1; bus.ls_addr_i = 32'h3F0;
      bus.ls_wdata_i = 32'hFFFFFFFF; bus.ls_wmask_i = 4'b1111;
      tick();
      rst = 1'b1;
      #2;
      checks++; if (bus.mem_we_o !== 1'b0 || bus.ls_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_mid_we_gnt: got we=%b gnt=%b want 0 0", bus.mem_we_o, bus.ls_gnt_o); end
      checks++; if (bus.pr_acess_instmem_o !== 2'b00 || bus.mem_addr_o !== 32'h40) begin errors++; $display("FAIL rst_mid_pr_addr: got %b/%h want 00/00000040", bus.pr_acess_instmem_o, bus.mem_addr_o); end
      tick();
      bus.ls_req_i = 1'b0;
      tick();
      rst = 1'b0;
      #2;
      checks++; if (bus.pr_acess_instmem_o !== 2'b00 || bus.mem_we_o !== 1'b0 || bus.ls_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_after: got pr=%b we=%b gnt=%b want 00 0 0", bus.pr_acess_instmem_o, bus.mem_we_o, bus.ls_gnt_o); end
      checks++; if (bus.fetch_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_after_frv: got %b want 0", bus.fetch_rvalid_o); end
      // abandoned store must not have reached the SRAM
      bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 32'h3F0;
      fq.push_back(32'h55555555);
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_fetch();
      bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 32'h100;
      #2;
      checks++; if (bus.mem_addr_o !== 32'h100 || bus.pr_acess_instmem_o !== 2'b00) begin errors++; $display("FAIL fetch_a0: got %h/%b want 00000100/00", bus.mem_addr_o, bus.pr_acess_instmem_o); end
      fq.push_back(exp_word(32'h100));
      tick();
      bus.fetch_addr_i = 32'h104;
      #2;
      checks++; if (bus.mem_addr_o !== 32'h104 || bus.pr_acess_instmem_o !== 2'b00) begin errors++; $display("FAIL fetch_a1: got %h/%b want 00000104/00", bus.mem_addr_o, bus.pr_acess_instmem_o); end
      checks++; if (bus.fetch_rvalid_o !== 1'b1) begin errors++; $display("FAIL fetch_rv: got %b want 1", bus.fetch_rvalid_o); end
      fq.push_back(exp_word(32'h104));
      tick();
      idle_inputs();
      tick(); tick();
   endtask

   task automatic test_load();
      bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 32'h104;
      bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = 32'h200;
      bus.ls_wmask_i = 4'b1111;
      fq.push_back(exp_word(32'h104));
      tick();
      #2;
      checks++; if (bus.ls_gnt_o !== 1'b1 || bus.pr_acess_instmem_o !== 2'b10 || bus.mem_addr_o !== 32'h200) begin errors++; $display("FAIL load_issue: got gnt=%b pr=%b addr=%h want 1 10 00000200", bus.ls_gnt_o, bus.pr_acess_instmem_o, bus.mem_addr_o); end
      checks++; if (bus.mem_we_o !== 1'b0 || bus.mem_wmask_o !== 4'b0000) begin errors++; $display("FAIL load_nowe: got we=%b mask=%b want 0 0000", bus.mem_we_o, bus.mem_wmask_o); end
      lq.push_back(32'hDEADBEEF);
      tick();
      bus.ls_req_i = 1'b0;
      #2;
      checks++; if (bus.pr_acess_instmem_o !== 2'b01 || bus.mem_addr_o !== 32'h104 || bus.ls_rvalid_o !== 1'b1) begin errors++; $display("FAIL load_resp: got pr=%b addr=%h rv=%b want 01 00000104 1", bus.pr_acess_instmem_o, bus.mem_addr_o, bus.ls_rvalid_o); end
      checks++; if (bus.fetch_rvalid_o !== 1'b0) begin errors++; $display("FAIL load_frv0: got %b want 0", bus.fetch_rvalid_o); end
      fq.push_back(exp_word(32'h104));
      tick();
      idle_inputs();
      #2;
      checks++; if (bus.fetch_rvalid_o !== 1'b1) begin errors++; $display("FAIL load_frv1: got %b want 1", bus.fetch_rvalid_o); end
      tick();
   endtask

   task automatic test_store();
      bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 32'h108;
      bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b1; bus.ls_addr_i = 32'h300;
      bus.ls_wdata_i = 32'h12345678; bus.ls_wmask_i = 4'b0011;
      #2;
      checks++; if (bus.mem_we_o !== 1'b0 || bus.mem_wmask_o !== 4'b0000) begin errors++; $display("FAIL st_idle: got we=%b mask=%b want 0 0000", bus.mem_we_o, bus.mem_wmask_o); end
      fq.push_back(exp_word(32'h108));
      tick();
      #2;
      checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_wmask_o !== 4'b0011 || bus.mem_wdata_o !== 32'h12345678 || bus.mem_addr_o !== 32'h300) begin errors++; $display("FAIL st_issue: got we=%b mask=%b d=%h a=%h want 1 0011 12345678 00000300", bus.mem_we_o, bus.mem_wmask_o, bus.mem_wdata_o, bus.mem_addr_o); end
      tick();
      bus.ls_req_i = 1'b0;
      #2;
      checks++; if (bus.mem_we_o !== 1'b0 || bus.ls_rvalid_o !== 1'b0 || bus.pr_acess_instmem_o !== 2'b01) begin errors++; $display("FAIL st_resp: got we=%b rv=%b pr=%b want 0 0 01", bus.mem_we_o, bus.ls_rvalid_o, bus.pr_acess_instmem_o); end
      fq.push_back(exp_word(32'h108));
      tick();
      bus.fetch_addr_i = 32'h300;
      fq.push_back(32'hAAAA5678);
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_starvation();
      logic [1:0] pr_exp [0:12];
      int gnts = 0;
      pr_exp = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01,
                 2'b00, 2'b00, 2'b10, 2'b01};
      bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 32'h10C;
      bus.ls_we_i = 1'b0; bus.ls_addr_i = 32'h200;
      for (int i = 0; i < 13; i++) begin
         bus.ls_req_i = (i < 12);
         #2;
         checks++;
         if (bus.pr_acess_instmem_o !== pr_exp[i]) begin errors++; $display("FAIL starve_pr[%0d]: got %b want %b", i, bus.pr_acess_instmem_o, pr_exp[i]); end
         if (pr_exp[i] == 2'b10) lq.push_back(32'hDEADBEEF);
         else                    fq.push_back(exp_word(32'h10C));
         if (i >= 1 && i <= 8 && bus.ls_gnt_o) gnts++;
         if (i == 10) begin
            checks++;
            if (bus.fetch_rvalid_o !== 1'b1) begin errors++; $display("FAIL starve_forced_frv: got %b want 1", bus.fetch_rvalid_o); end
         end
         tick();
      end
      idle_inputs();
      checks++; if (gnts != 4) begin errors++; $display("FAIL starve_gnts: got %0d want 4", gnts); end
      tick(); tick();
   endtask

   task automatic test_simultaneous();
      bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 32'h110;
      bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = 32'h204;
      fq.push_back(exp_word(32'h110));
      tick();
      #2;
      checks++; if (bus.ls_gnt_o !== 1'b1 || bus.mem_addr_o !== 32'h204) begin errors++; $display("FAIL sim_issue: got gnt=%b addr=%h want 1 00000204", bus.ls_gnt_o, bus.mem_addr_o); end
      lq.push_back(exp_word(32'h204));
      tick();
      bus.ls_req_i = 1'b0;
      #2;
      checks++; if (bus.pr_acess_instmem_o !== 2'b01 || bus.mem_addr_o !== 32'h110) begin errors++; $display("FAIL sim_resp: got pr=%b addr=%h want 01 00000110", bus.pr_acess_instmem_o, bus.mem_addr_o); end
      fq.push_back(exp_word(32'h110));
      tick();
      idle_inputs();
      #2;
      checks++; if (bus.fetch_rvalid_o !== 1'b1) begin errors++; $display("FAIL sim_frv: got %b want 1", bus.fetch_rvalid_o); end
      tick(); tick();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) sram[i] = exp_word(32'(i * 4));
      bus.ls_addr_i  = '0;
      bus.ls_wdata_i = '0;
      idle_inputs();
      test_reset();
      test_fetch();
      test_load();
      test_store();
      test_starvation();
      test_simultaneous();
      checks++; if (fq.size() != 0) begin errors++; $display("FAIL fetch_drain: got %0d pending want 0", fq.size()); end
      checks++; if (lq.size() != 0) begin errors++; $display("FAIL ls_drain: got %0d pending want 0", lq.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
